ysyx_25030085_alu_arb: RTL and testbench

- Shares the single combinational ALU between two requesters: requester 0 is the EXU and requester 1 is the LSU address/branch-target generator.
- Arbitrates round-robin, latches the winner's operands, drives the ALU, registers the result and returns it over a valid/ready response channel.
- Sits between the decode/execute stage and the ALU instance; the ALU itself stays outside this block.

---
 rtl/ysyx_25030085_alu_pkg.sv | 23 ++
 rtl/ysyx_25030085_rr_arb2.sv | 25 ++
 rtl/ysyx_25030085_alu_arb.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_25030085_alu_arb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030085_alu_pkg.sv
// rtl/ysyx_25030085_alu_pkg.sv - shared ALU opcodes, arbiter state encoding and width defaults
package ysyx_25030085_alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRA   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_OR    = 4'b0111;
    localparam logic [3:0] ALU_AND   = 4'b1000;
    localparam logic [3:0] ALU_PCADD = 4'b1001;
    localparam logic [3:0] ALU_SUB   = 4'b1010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/ysyx_25030085_rr_arb2.sv
// rtl/ysyx_25030085_rr_arb2.sv - combinational 2-way round-robin grant
module ysyx_25030085_rr_arb2
    import ysyx_25030085_alu_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        grant  = 2'b00;
        // rr_ptr only breaks ties; a lone requester always wins.
        if (valid == 2'b11) begin
            winner = rr_ptr;
        end else begin
            winner = valid[1];
        end
        if (valid != 2'b00) begin
            grant = winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ysyx_25030085_alu_arb.sv
// rtl/ysyx_25030085_alu_arb.sv - round-robin EXU/LSU sharing of one ALU; ALU_ARB_STATS_EN adds counters
module ysyx_25030085_alu_arb
    import ysyx_25030085_alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_rs1,
    input  logic [DATA_W-1:0] req0_rs2,
    input  logic [DATA_W-1:0] req0_imm,
    input  logic [DATA_W-1:0] req0_pc,
    input  logic [OP_W-1:0]   req0_aluop,
    input  logic              req0_alusrc,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_rs1,
    input  logic [DATA_W-1:0] req1_rs2,
    input  logic [DATA_W-1:0] req1_imm,
    input  logic [DATA_W-1:0] req1_pc,
    input  logic [OP_W-1:0]   req1_aluop,
    input  logic              req1_alusrc,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [DATA_W-1:0] alu_rs1,
    output logic [DATA_W-1:0] alu_rs2,
    output logic [DATA_W-1:0] alu_imm,
    output logic [DATA_W-1:0] alu_pc,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_src,
    input  logic [DATA_W-1:0] alu_result,
`ifdef ALU_ARB_STATS_EN
    output logic [31:0]       stat_grant0,
    output logic [31:0]       stat_grant1,
    output logic [31:0]       stat_conflict,
    output logic [31:0]       stat_rsp_stall,
`endif
    output logic              busy
);

    logic [1:0] state;
    logic       rr_ptr;
    logic       owner;
    logic [1:0] grant;
    logic       winner;
    logic       in_idle;
    logic       in_resp;
    logic       take;
    logic       rsp_take;

    logic [DATA_W-1:0] win_rs1;
    logic [DATA_W-1:0] win_rs2;
    logic [DATA_W-1:0] win_imm;
    logic [DATA_W-1:0] win_pc;
    logic [OP_W-1:0]   win_op;
    logic              win_src;

    logic [DATA_W-1:0] lat_rs1;
    logic [DATA_W-1:0] lat_rs2;
    logic [DATA_W-1:0] lat_imm;
    logic [DATA_W-1:0] lat_pc;
    logic [OP_W-1:0]   lat_op;
    logic              lat_src;

    ysyx_25030085_rr_arb2 u_rr_arb2 (
        .valid  ({req1_valid, req0_valid}),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .winner (winner)
    );

    assign in_idle  = (state == ST_IDLE);
    assign in_resp  = (state == ST_RESP);
    assign take     = in_idle & (grant != 2'b00);
    assign rsp_take = in_resp & (owner ? rsp1_ready : rsp0_ready);

    assign req0_ready = in_idle & grant[0];
    assign req1_ready = in_idle & grant[1];
    assign rsp0_valid = in_resp & ~owner;
    assign rsp1_valid = in_resp & owner;
    assign busy       = ~in_idle;

    always_comb begin
        win_rs1 = req0_rs1;
        win_rs2 = req0_rs2;
        win_imm = req0_imm;
        win_pc  = req0_pc;
        win_op  = req0_aluop;
        win_src = req0_alusrc;
        if (winner) begin
            win_rs1 = req1_rs1;
            win_rs2 = req1_rs2;
            win_imm = req1_imm;
            win_pc  = req1_pc;
            win_op  = req1_aluop;
            win_src = req1_alusrc;
        end
    end

    // The ALU only ever sees latched operands so requesters may move on after the handshake.
    assign alu_rs1 = lat_rs1;
    assign alu_rs2 = lat_rs2;
    assign alu_imm = lat_imm;
    assign alu_pc  = lat_pc;
    assign alu_op  = lat_op;
    assign alu_src = lat_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            lat_rs1    <= '0;
            lat_rs2    <= '0;
            lat_imm    <= '0;
            lat_pc     <= '0;
            lat_op     <= '0;
            lat_src    <= 1'b0;
            rsp_result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        lat_rs1 <= win_rs1;
                        lat_rs2 <= win_rs2;
                        lat_imm <= win_imm;
                        lat_pc  <= win_pc;
                        lat_op  <= win_op;
                        lat_src <= win_src;
                        owner   <= winner;
                        rr_ptr  <= ~winner;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result <= alu_result;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_take) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant0    <= '0;
            stat_grant1    <= '0;
            stat_conflict  <= '0;
            stat_rsp_stall <= '0;
        end else begin
            if (take && !winner) begin
                stat_grant0 <= stat_grant0 + 32'd1;
            end
            if (take && winner) begin
                stat_grant1 <= stat_grant1 + 32'd1;
            end
            if (take && req0_valid && req1_valid) begin
                stat_conflict <= stat_conflict + 32'd1;
            end
            if (in_resp && !rsp_take) begin
                stat_rsp_stall <= stat_rsp_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25030085_alu_arb.sv
// tb/tb_ysyx_25030085_alu_arb.sv - directed self-checking bench for ysyx_25030085_alu_arb
module tb_ysyx_25030085_alu_arb;
    import ysyx_25030085_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_alusrc;
    logic [31:0] req0_rs1, req0_rs2, req0_imm, req0_pc;
    logic [3:0]  req0_aluop;
    logic        req1_valid, req1_ready, req1_alusrc;
    logic [31:0] req1_rs1, req1_rs2, req1_imm, req1_pc;
    logic [3:0]  req1_aluop;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic [31:0] alu_rs1, alu_rs2, alu_imm, alu_pc, alu_result;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        busy;
`ifdef ALU_ARB_STATS_EN
    logic [31:0] stat_grant0, stat_grant1, stat_conflict, stat_rsp_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_25030085_alu_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_imm(req0_imm), .req0_pc(req0_pc),
        .req0_aluop(req0_aluop), .req0_alusrc(req0_alusrc),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_imm(req1_imm), .req1_pc(req1_pc),
        .req1_aluop(req1_aluop), .req1_alusrc(req1_alusrc),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_op(alu_op), .alu_src(alu_src), .alu_result(alu_result),
`ifdef ALU_ARB_STATS_EN
        .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
        .stat_conflict(stat_conflict), .stat_rsp_stall(stat_rsp_stall),
`endif
        .busy(busy)
    );

    // Stand-in for the external combinational ALU.
    logic [31:0] src2;
    always_comb begin
        src2       = alu_src ? alu_imm : alu_rs2;
        alu_result = 32'd0;
        case (alu_op)
            ALU_ADD:   alu_result = alu_rs1 + src2;
            ALU_SUB:   alu_result = alu_rs1 - src2;
            ALU_SLTU:  alu_result = {31'd0, alu_rs1 < src2};
            ALU_AND:   alu_result = alu_rs1 & src2;
            ALU_OR:    alu_result = alu_rs1 | src2;
            ALU_XOR:   alu_result = alu_rs1 ^ src2;
            ALU_PCADD: alu_result = alu_pc + src2;
            default:   alu_result = 32'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req0_rs1 = 0; req0_rs2 = 0; req0_imm = 0; req0_pc = 0;
        req0_aluop = 0; req0_alusrc = 0;
        req1_valid = 0; req1_rs1 = 0; req1_rs2 = 0; req1_imm = 0; req1_pc = 0;
        req1_aluop = 0; req1_alusrc = 0;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic set_pair();
        req0_rs1 = 32'd10; req0_rs2 = 32'd3; req0_aluop = ALU_SUB; req0_alusrc = 0;
        req1_pc = 32'h8000_0000; req1_imm = 32'h10; req1_rs1 = 32'h55; req1_rs2 = 32'h66;
        req1_aluop = ALU_PCADD; req1_alusrc = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0) begin
            errors++; $display("FAIL reset_hs got %b exp 0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}); end
        checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", rsp_result); end
        checks++; if ({alu_rs1, alu_rs2, alu_imm, alu_pc} !== 128'd0 || alu_op !== 4'd0 || alu_src !== 1'b0) begin
            errors++; $display("FAIL reset_alu got rs1 %h op %h exp 0", alu_rs1, alu_op); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_single();
        req0_valid = 1; req0_rs1 = 5; req0_rs2 = 7; req0_aluop = ALU_ADD; req0_alusrc = 0;
        rsp0_ready = 1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL single_c0_ready got %b%b exp 01", req1_ready, req0_ready); end
        tick();
        req0_valid = 0;
        #1;
        checks++; if (busy !== 1'b1 || req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL single_c1_exec got busy %b rv %b exp 1 0", busy, rsp0_valid); end
        checks++; if (alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7 || alu_op !== ALU_ADD) begin
            errors++; $display("FAIL single_c1_alu got %h %h exp 5 7", alu_rs1, alu_rs2); end
        tick();
        checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 32'd12) begin
            errors++; $display("FAIL single_c2_rsp got v %b res %h exp 1 0000000c", rsp0_valid, rsp_result); end
        tick();
        checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL single_c3_idle got busy %b exp 0", busy); end
        rsp0_ready = 0;
    endtask

    task automatic test_conflict();
        logic [31:0] exp_res;
        set_pair();
        req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
        #1;
        for (int p = 0; p < 8; p++) begin
            checks++; if (req0_ready !== (p % 2 == 0) || req1_ready !== (p % 2 == 1)) begin
                errors++; $display("FAIL conflict_grant op %0d got %b%b", p, req1_ready, req0_ready); end
            tick();
            tick();
            exp_res = (p % 2 == 0) ? 32'd7 : 32'h8000_0010;
            checks++; if (rsp0_valid !== (p % 2 == 0) || rsp1_valid !== (p % 2 == 1) || rsp_result !== exp_res) begin
                errors++; $display("FAIL conflict_rsp op %0d got v %b%b res %h exp %h", p, rsp1_valid, rsp0_valid, rsp_result, exp_res); end
            tick();
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic test_backpressure();
        set_pair();
        req1_valid = 1; rsp1_ready = 0;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_grant1 got %b exp 1", req1_ready); end
        tick();
        req1_valid = 0; req0_valid = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp1_valid !== 1'b1 || rsp_result !== 32'h8000_0010 || req0_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc %0d got v %b res %h r0 %b", i, rsp1_valid, rsp_result, req0_ready); end
            tick();
        end
        rsp1_ready = 1;
        #1;
        checks++; if (rsp1_valid !== 1'b1 || rsp_result !== 32'h8000_0010) begin
            errors++; $display("FAIL bp_release got v %b res %h", rsp1_valid, rsp_result); end
        tick();
        rsp1_ready = 0; rsp0_ready = 1;
        #1;
        checks++; if (req0_ready !== 1'b1 || rsp1_valid !== 1'b0) begin
            errors++; $display("FAIL bp_next_grant got r0 %b exp 1", req0_ready); end
        tick();
        req0_valid = 0;
        tick();
        checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd7) begin
            errors++; $display("FAIL bp_req0_rsp got v %b res %h exp 7", rsp0_valid, rsp_result); end
        tick();
        rsp0_ready = 0;
    endtask

    task automatic test_reset_mid_op();
        req0_valid = 1; req0_rs1 = 9; req0_rs2 = 4; req0_aluop = ALU_AND; req0_alusrc = 0;
        rsp0_ready = 1;
        tick();
        req0_valid = 0;
        #1;
        checks++; if (busy !== 1'b1 || alu_rs1 !== 32'd9) begin
            errors++; $display("FAIL midop_exec got busy %b rs1 %h", busy, alu_rs1); end
        rst_n = 0;
        #1;
        checks++; if (busy !== 1'b0 || alu_rs1 !== 32'd0 || alu_op !== 4'd0 || rsp_result !== 32'd0 || rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL midop_async got busy %b rs1 %h res %h", busy, alu_rs1, rsp_result); end
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL midop_after cyc %0d got v %b%b busy %b", i, rsp1_valid, rsp0_valid, busy); end
        end
        rsp0_ready = 0;
    endtask

    task automatic test_isolation();
        req0_valid = 1; req0_rs1 = 1; req0_rs2 = 2; req0_aluop = ALU_SLTU; req0_alusrc = 0;
        rsp0_ready = 1;
        tick();
        req0_valid = 0; req0_rs1 = 32'd100;
        #1;
        checks++; if (alu_rs1 !== 32'd1) begin errors++; $display("FAIL iso_alu_rs1 got %h exp 1", alu_rs1); end
        tick();
        checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd1) begin
            errors++; $display("FAIL iso_result got v %b res %h exp 1", rsp0_valid, rsp_result); end
        tick();
        rsp0_ready = 0;
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        clear_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        set_pair();
        for (int p = 0; p < 3; p++) begin
            req0_valid = 1; req1_valid = 1;
            rsp0_ready = (p != 0); rsp1_ready = 1;
            tick();
            req0_valid = 0;
            tick();
            if (p == 0) begin
                tick();
                tick();
                rsp0_ready = 1;
            end
            tick();
            tick();
            req1_valid = 0;
            tick();
            tick();
        end
        checks++; if (stat_grant0 !== 32'd3) begin errors++; $display("FAIL stat_grant0 got %0d exp 3", stat_grant0); end
        checks++; if (stat_grant1 !== 32'd3) begin errors++; $display("FAIL stat_grant1 got %0d exp 3", stat_grant1); end
        checks++; if (stat_conflict !== 32'd3) begin errors++; $display("FAIL stat_conflict got %0d exp 3", stat_conflict); end
        checks++; if (stat_rsp_stall !== 32'd2) begin errors++; $display("FAIL stat_rsp_stall got %0d exp 2", stat_rsp_stall); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_reset();
        test_conflict();
        test_reset();
        test_backpressure();
        test_reset_mid_op();
        test_isolation();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
